inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the Fetcher and the memory controller.
//  - Hits return in 1 cycle.
//  - Misses issue a single word request to the memory controller, refill the line and forward the word.
//  - A clear (branch redirect) discards any in-flight result without aborting the memory access.
// PARAMETERS
//  INDEX_BITS  6  line index width; 2**INDEX_BITS lines; index=pc[INDEX_BITS+1:2], tag=pc[31:INDEX_BITS+2]
// PORTS
//  clk_in             in   1   system clock
//  rst_in             in   1   asynchronous, active-low reset
//  rdy_in             in   1   global ready; low freezes all state
//  clear_in           in   1   redirect: drop pending/outgoing instruction
//  fetch_valid_in     in   1   Fetcher presents fetch_pc_in
//  fetch_pc_in        in   32  fetch address; bits [1:0] ignored
//  fetch_ready_out    out  1   cache accepts a lookup this cycle
//  inst_valid_out     out  1   one-cycle pulse: inst_out/inst_pc_out valid
//  inst_out           out  32  instruction word
//  inst_pc_out        out  32  pc of inst_out
//  mem_req_out        out  1   word request to memory controller, held until served
//  mem_pc_out         out  32  requested word address
//  mem_inst_ready_in  in   1   memory controller word-done pulse
//  mem_inst_in        in   32  word from memory controller
//  hit_cnt_out        out  32  (ICACHE_STATS_EN only) hit count
//  miss_cnt_out       out  32  (ICACHE_STATS_EN only) miss count
// BEHAVIOUR
//  - Reset (rst_in=0, async):
//    - all line valid bits cleared; state=IDLE
//    - inst_valid_out, mem_req_out, fetch_ready_out are 0; inst_out, inst_pc_out, mem_pc_out are 0
//    - fetch_ready_out rises the first cycle after release.
//  - Reset mid-miss abandons the request; no fill occurs.
//  - rdy_in=0: no state, array or output register changes; mem_inst_ready_in ignored that cycle.
//  - State IDLE:
//    - fetch_ready_out=1.
//    - On fetch_valid_in & !clear_in, if hit (valid & tag match):
//      - next edge: inst_valid_out=1, inst_out=data, inst_pc_out=fetch_pc_in; stay IDLE (latency 1).
//    - If miss:
//      - next edge: mem_req_out=1, mem_pc_out={fetch_pc_in[31:2],2'b00}; latch pc; go MISS_WAIT.
//    - fetch_valid_in & clear_in together: the lookup is ignored.
//  - State MISS_WAIT:
//    - fetch_ready_out=0; mem_req_out/mem_pc_out held stable.
//    - On mem_inst_ready_in:
//      - write tag/data, set valid
//      - inst_valid_out=1 with word and latched pc next cycle
//      - mem_req_out=0; go IDLE.
//    - On clear_in without mem_inst_ready_in: go DRAIN.
//    - On clear_in with mem_inst_ready_in: fill the line, no output, go IDLE.
//  - State DRAIN:
//    - fetch_ready_out=0; mem_req_out stays 1 (the memory controller cannot abort).
//    - On mem_inst_ready_in: fill the line, no output, go IDLE. clear_in has no further effect.
//  - clear_in in any state forces inst_valid_out=0 on the next edge.
//  - inst_valid_out is a single-cycle pulse; the Fetcher must take it (no backpressure).
//  - Lookup occurs only in IDLE, so a fill and a lookup never touch the array in the same cycle.
//  - Replacement: an incoming fill overwrites the indexed line unconditionally.
//  - mem_inst_ready_in seen in IDLE: ignored.
// CONFIGURATION
//  - ICACHE_STATS_EN defined:
//    - hit_cnt_out/miss_cnt_out present.
//    - Each is +1 per accepted lookup (rdy_in=1, IDLE, fetch_valid_in, !clear_in) that hits or misses.
//    - Both wrap at 2**32 and reset to 0.
//  - ICACHE_STATS_EN undefined: both ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  - Cold fetch of 0x100:
//    - mem_req_out=1, mem_pc_out=0x100 next cycle.
//    - Return 0x00500093 after 3 cycles -> inst_valid_out pulse with inst_out=0x00500093, inst_pc_out=0x100.
//  - Refetch 0x100 -> no mem_req_out; inst_valid_out=1 on the next cycle with 0x00500093.
//  - Conflict (INDEX_BITS=6):
//    - fetch 0x200 (same index as 0x100) -> miss, refill 0x13.
//    - Refetch 0x100 -> miss again.
//  - clear_in during MISS_WAIT for 0x40:
//    - mem_req_out stays 1 until ready; no inst_valid_out.
//    - Refetch 0x40 -> hit.
//  - rdy_in=0 for 4 cycles while mem_inst_ready_in pulses:
//    - no fill, no output, state unchanged.
//    - Resume, pulse again -> normal fill.
//  - rst_in low mid-MISS_WAIT:
//    - all outputs 0 asynchronously.
//    - After release, fetch of the old hit address misses.
//    - With ICACHE_STATS_EN, the counters read 0.

Source files
------------

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the Fetcher and the memory controller.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module inst_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        fetch_valid_in,
  input  logic [31:0] fetch_pc_in,
  output logic        fetch_ready_out,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_out,
  output logic        mem_req_out,
  output logic [31:0] mem_pc_out,
  input  logic        mem_inst_ready_in,
  input  logic [31:0] mem_inst_in
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_out,
  output logic [31:0] miss_cnt_out
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    MISS_WAIT,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic        ready_q, ready_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_pc_q, mem_pc_d;

  logic [INDEX_BITS-1:0] fetch_idx, fill_idx;
  logic [TAG_BITS-1:0]   fetch_tag, fill_tag;
  logic                  lookup, hit, fill_en;

  assign fetch_idx = fetch_pc_in[INDEX_BITS+1:2];
  assign fetch_tag = fetch_pc_in[31:INDEX_BITS+2];
  // The pending miss address doubles as the latched pc for the refill.
  assign fill_idx  = mem_pc_q[INDEX_BITS+1:2];
  assign fill_tag  = mem_pc_q[31:INDEX_BITS+2];

  assign lookup = (state_q == IDLE) && fetch_valid_in && !clear_in;
  assign hit    = lookup && valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    mem_req_d    = mem_req_q;
    mem_pc_d     = mem_pc_q;
    fill_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          inst_valid_d = 1'b1;
          inst_d       = data_mem[fetch_idx];
          inst_pc_d    = fetch_pc_in;
        end else if (lookup) begin
          mem_req_d = 1'b1;
          mem_pc_d  = {fetch_pc_in[31:2], 2'b00};
          state_d   = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (mem_inst_ready_in) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!clear_in) begin
            inst_valid_d = 1'b1;
            inst_d       = mem_inst_in;
            inst_pc_d    = mem_pc_q;
          end
        end else if (clear_in) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The memory controller cannot abort, so the word is still taken into the array.
        if (mem_inst_ready_in) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_in) inst_valid_d = 1'b0;
    ready_d = (state_d == IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      ready_q      <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_pc_q     <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      mem_req_q    <= mem_req_d;
      mem_pc_q     <= mem_pc_d;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_inst_in;
    end
  end

  assign fetch_ready_out = ready_q;
  assign inst_valid_out  = inst_valid_q;
  assign inst_out        = inst_q;
  assign inst_pc_out     = inst_pc_q;
  assign mem_req_out     = mem_req_q;
  assign mem_pc_out      = mem_pc_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy_in && lookup) begin
      if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_out  = hit_cnt_q;
  assign miss_cnt_out = miss_cnt_q;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus random fetches scored against a line-level cache model.
module tb_inst_cache;

  localparam int INDEX_BITS = 6;
  localparam int LINES      = 1 << INDEX_BITS;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        fetch_valid_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_ready_out;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic        mem_req_out;
  logic [31:0] mem_pc_out;
  logic        mem_inst_ready_in;
  logic [31:0] mem_inst_in;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_out;
  logic [31:0] miss_cnt_out;
`endif

  inst_cache #(.INDEX_BITS(INDEX_BITS)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear_in          (clear_in),
    .fetch_valid_in    (fetch_valid_in),
    .fetch_pc_in       (fetch_pc_in),
    .fetch_ready_out   (fetch_ready_out),
    .inst_valid_out    (inst_valid_out),
    .inst_out          (inst_out),
    .inst_pc_out       (inst_pc_out),
    .mem_req_out       (mem_req_out),
    .mem_pc_out        (mem_pc_out),
    .mem_inst_ready_in (mem_inst_ready_in),
    .mem_inst_in       (mem_inst_in)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_out       (hit_cnt_out),
    .miss_cnt_out      (miss_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: which word each line holds, indexed the way the cache addresses it.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  int          n_hit  = 0;
  int          n_miss = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> (INDEX_BITS + 2)));
  endfunction

  task automatic model_fill(input logic [31:0] pc, input logic [31:0] word);
    m_valid[idx_of(pc)] = 1'b1;
    m_tag[idx_of(pc)]   = pc >> (INDEX_BITS + 2);
    m_data[idx_of(pc)]  = word;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    n_hit  = 0;
    n_miss = 0;
  endtask

  // One complete fetch from IDLE; on a miss the memory answers with word after lat idle cycles.
  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] word, input int lat);
    bit          exp_hit;
    logic [31:0] apc;
    exp_hit = model_hit(pc);
    apc     = {pc[31:2], 2'b00};
    check("ready_before_fetch", 32'(fetch_ready_out), 32'd1);
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    if (exp_hit) begin
      n_hit++;
      check("hit_valid", 32'(inst_valid_out), 32'd1);
      check("hit_inst", inst_out, m_data[idx_of(pc)]);
      check("hit_pc", inst_pc_out, pc);
      check("hit_no_req", 32'(mem_req_out), 32'd0);
    end else begin
      n_miss++;
      check("miss_req", 32'(mem_req_out), 32'd1);
      check("miss_pc", mem_pc_out, apc);
      check("miss_no_valid", 32'(inst_valid_out), 32'd0);
      check("miss_not_ready", 32'(fetch_ready_out), 32'd0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk_in);
        check("miss_req_held", 32'(mem_req_out), 32'd1);
        check("miss_pc_held", mem_pc_out, apc);
      end
      mem_inst_ready_in = 1'b1;
      mem_inst_in       = word;
      @(negedge clk_in);
      mem_inst_ready_in = 1'b0;
      check("fill_valid", 32'(inst_valid_out), 32'd1);
      check("fill_inst", inst_out, word);
      check("fill_pc", inst_pc_out, apc);
      check("fill_req_drop", 32'(mem_req_out), 32'd0);
      check("fill_ready", 32'(fetch_ready_out), 32'd1);
      model_fill(pc, word);
    end
    @(negedge clk_in);
    check("pulse_end", 32'(inst_valid_out), 32'd0);
  endtask

  // Starts a miss and leaves the cache in MISS_WAIT with the request visible.
  task automatic start_miss(input logic [31:0] pc);
    fetch_valid_in = 1'b1;
    fetch_pc_in    = pc;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    n_miss++;
    check("start_miss_req", 32'(mem_req_out), 32'd1);
    check("start_miss_pc", mem_pc_out, {pc[31:2], 2'b00});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(fetch_ready_out), 32'd0);
    check({tag, "_valid"}, 32'(inst_valid_out), 32'd0);
    check({tag, "_inst"}, inst_out, 32'd0);
    check({tag, "_inst_pc"}, inst_pc_out, 32'd0);
    check({tag, "_req"}, 32'(mem_req_out), 32'd0);
    check({tag, "_mem_pc"}, mem_pc_out, 32'd0);
`ifdef ICACHE_STATS_EN
    check({tag, "_hits"}, hit_cnt_out, 32'd0);
    check({tag, "_misses"}, miss_cnt_out, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] pc;
    rst_in            = 1'b0;
    rdy_in            = 1'b1;
    clear_in          = 1'b0;
    fetch_valid_in    = 1'b0;
    fetch_pc_in       = '0;
    mem_inst_ready_in = 1'b0;
    mem_inst_in       = '0;
    model_reset();

    // Reset state, then fetch_ready rises on the first edge after release.
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b1;
    #1;
    check("ready_at_release", 32'(fetch_ready_out), 32'd0);
    @(negedge clk_in);
    check("ready_after_release", 32'(fetch_ready_out), 32'd1);

    // Cold miss, refetch hit, conflict eviction.
    do_fetch(32'h100, 32'h0050_0093, 3);
    do_fetch(32'h100, 32'hDEAD_BEEF, 3);
    do_fetch(32'h200, 32'h0000_0013, 2);
    do_fetch(32'h100, 32'h0050_0093, 1);

    // Spurious memory pulse while IDLE is ignored.
    mem_inst_ready_in = 1'b1;
    mem_inst_in       = 32'hFFFF_FFFF;
    @(negedge clk_in);
    mem_inst_ready_in = 1'b0;
    check("idle_pulse_no_valid", 32'(inst_valid_out), 32'd0);
    check("idle_pulse_no_req", 32'(mem_req_out), 32'd0);
    do_fetch(32'h100, 32'h0, 0);

    // Fetch together with clear in IDLE is dropped.
    fetch_valid_in = 1'b1;
    clear_in       = 1'b1;
    fetch_pc_in    = 32'h500;
    @(negedge clk_in);
    fetch_valid_in = 1'b0;
    clear_in       = 1'b0;
    check("fetch_clear_no_req", 32'(mem_req_out), 32'd0);
    check("fetch_clear_no_valid", 32'(inst_valid_out), 32'd0);
    check("fetch_clear_ready", 32'(fetch_ready_out), 32'd1);

    // Clear during MISS_WAIT: request held, word filled silently, later hit.
    start_miss(32'h40);
    clear_in = 1'b1;
    @(negedge clk_in);
    check("drain_req", 32'(mem_req_out), 32'd1);
    check("drain_not_ready", 32'(fetch_ready_out), 32'd0);
    check("drain_no_valid", 32'(inst_valid_out), 32'd0);
    @(negedge clk_in);
    clear_in = 1'b0;
    check("drain_req_held", 32'(mem_req_out), 32'd1);
    check("drain_pc_held", mem_pc_out, 32'h40);
    mem_inst_ready_in = 1'b1;
    mem_inst_in       = 32'h00A0_0113;
    @(negedge clk_in);
    mem_inst_ready_in = 1'b0;
    check("drain_fill_no_valid", 32'(inst_valid_out), 32'd0);
    check("drain_fill_req_drop", 32'(mem_req_out), 32'd0);
    check("drain_fill_ready", 32'(fetch_ready_out), 32'd1);
    model_fill(32'h40, 32'h00A0_0113);
    do_fetch(32'h40, 32'h0, 0);

    // Clear coinciding with the memory word: fill, no output.
    start_miss(32'h80);
    clear_in          = 1'b1;
    mem_inst_ready_in = 1'b1;
    mem_inst_in       = 32'h1234_5678;
    @(negedge clk_in);
    clear_in          = 1'b0;
    mem_inst_ready_in = 1'b0;
    check("clear_fill_no_valid", 32'(inst_valid_out), 32'd0);
    check("clear_fill_req_drop", 32'(mem_req_out), 32'd0);
    model_fill(32'h80, 32'h1234_5678);
    do_fetch(32'h80, 32'h0, 0);

    // rdy_in low freezes everything, memory pulses are ignored.
    start_miss(32'hC0);
    rdy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_inst_ready_in = (i % 2 == 0);
      mem_inst_in       = 32'hBAD0_0000 + 32'(i);
      @(negedge clk_in);
      check("frozen_req", 32'(mem_req_out), 32'd1);
      check("frozen_no_valid", 32'(inst_valid_out), 32'd0);
      check("frozen_not_ready", 32'(fetch_ready_out), 32'd0);
    end
    rdy_in            = 1'b1;
    mem_inst_ready_in = 1'b0;
    @(negedge clk_in);
    check("resume_still_waiting", 32'(mem_req_out), 32'd1);
    mem_inst_ready_in = 1'b1;
    mem_inst_in       = 32'h0C0F_FEE0;
    @(negedge clk_in);
    mem_inst_ready_in = 1'b0;
    check("resume_fill_valid", 32'(inst_valid_out), 32'd1);
    check("resume_fill_inst", inst_out, 32'h0C0F_FEE0);
    check("resume_fill_pc", inst_pc_out, 32'hC0);
    model_fill(32'hC0, 32'h0C0F_FEE0);
    @(negedge clk_in);
    do_fetch(32'hC0, 32'h0, 0);

    // Random fetches over a small pool so lines collide and get evicted.
    for (int n = 0; n < 80; n++) begin
      pc = (32'($urandom_range(0, 2)) << (INDEX_BITS + 2)) | (32'($urandom_range(0, 7)) << 2);
      do_fetch(pc, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        mem_inst_ready_in = 1'b1;
        mem_inst_in       = $urandom;
        @(negedge clk_in);
        mem_inst_ready_in = 1'b0;
        check("rand_idle_pulse", 32'(inst_valid_out), 32'd0);
      end
    end
`ifdef ICACHE_STATS_EN
    check("stats_hits", hit_cnt_out, 32'(n_hit));
    check("stats_misses", miss_cnt_out, 32'(n_miss));
`endif

    // Reset in the middle of a miss: outputs drop at once and nothing is filled.
    do_fetch(32'h100, 32'h0050_0093, 1);
    start_miss(32'h300);
    #2;
    rst_in = 1'b0;
    #1;
    check_all_zero("async_reset");
    mem_inst_ready_in = 1'b1;
    mem_inst_in       = 32'h5555_AAAA;
    @(negedge clk_in);
    mem_inst_ready_in = 1'b0;
    check_all_zero("held_reset");
    rst_in = 1'b1;
    model_reset();
    @(negedge clk_in);
    check("ready_after_rereset", 32'(fetch_ready_out), 32'd1);
    check("no_req_after_rereset", 32'(mem_req_out), 32'd0);
    do_fetch(32'h100, 32'h0050_0093, 2);
    do_fetch(32'h300, 32'h0000_0073, 0);
`ifdef ICACHE_STATS_EN
    check("stats_hits_after_reset", hit_cnt_out, 32'(n_hit));
    check("stats_misses_after_reset", miss_cnt_out, 32'(n_miss));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
